div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) sitting beside the single-cycle ALU in EX.
//  Takes the same operand1/operand2 the ALU sees, but answers over a valid/ready handshake.
//  The core stalls until resp_valid. Radix-2 restoring divider: one quotient bit per cycle.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  req_valid   in   1      request present; op/operand1/operand2 valid
//  req_ready   out  1      unit can accept (IDLE only)
//  op          in   2      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  operand1    in   WIDTH  dividend (rs1)
//  operand2    in   WIDTH  divisor (rs2)
//  resp_valid  out  1      result available
//  resp_ready  in   1      consumer takes result
//  result      out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
//  busy        out  1      high in CALC or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, busy=0, result=0, counter=0.
//  FSM: IDLE -> CALC (normal accept) | DONE (special case); CALC -> DONE after WIDTH iterations;
//       DONE -> IDLE on resp_valid && resp_ready.
//  Accept = req_valid && req_ready, sampled at a rising edge. op and operands are captured there.
//  After capture, input changes are ignored.
//  Signed ops (DIV/REM): divide |operand1| by |operand2|.
//   - Quotient is negated iff the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - Sign fix-up is applied on the CALC->DONE edge.
//  Unsigned ops: operands are used as-is.
//  Special cases, resolved at accept and going straight to DONE (latency 1):
//   - divisor==0: DIV/DIVU -> all ones; REM/REMU -> operand1.
//   - DIV/REM with operand1=100..0 and operand2=all ones:
//     DIV -> 100..0 (overflow); REM -> 0.
//  Normal latency: accept at edge N; resp_valid high after edge N+WIDTH+1 (33 for WIDTH=32).
//  CALC iteration: rem={rem[W-2:0],dvd[W-1]}; dvd<<=1.
//   - If rem >= divisor: rem -= divisor, shift in quotient bit 1.
//   - Otherwise shift in 0.
//   - Use a WIDTH+1-bit subtract; no truncation of the compare.
//  DONE: result and resp_valid held stable until the handshake. Backpressure is unbounded.
//  req_ready=0 in CALC/DONE. After the response handshake, the FSM is IDLE next cycle.
//  No same-cycle response+accept: req_ready rises the cycle after the handshake.
//  req_valid in CALC/DONE is not accepted and has no side effect.
//  resp_ready while not resp_valid is ignored.
//  busy = (state != IDLE).
//  Reset mid-operation: the in-flight op is discarded, with no response ever produced.
// TESTING
//  DIVU 100/7 -> result 14, resp_valid 33 cycles after accept; REMU 100/7 -> 2.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//  DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both 1 cycle after accept.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; latency 1.
//  Hold resp_ready=0 for 5 cycles in DONE and toggle the operands.
//   -> result stable, req_ready=0; IDLE the cycle after the handshake.
//  Assert rst at CALC cycle 10.
//   -> all outputs take reset values immediately; no resp_valid follows.
//   -> A new DIVU 9/3 after reset returns 3.

Source files
------------

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_if
//  Description : Request/response bundle between EX-stage issue logic and the
//                multi-cycle divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   // Requester side (core / testbench)
   modport master (
      output req_valid, op, operand1, operand2, resp_ready,
      input  req_ready, resp_valid, result, busy
   );

   // Divider side
   modport slave (
      input  req_valid, op, operand1, operand2, resp_ready,
      output req_ready, resp_valid, result, busy
   );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2
//                restoring, one quotient bit per cycle, valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst,
   div_if.slave   bus
);

   localparam int               CW    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    C_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dvd;      // dividend shifts out the top, quotient fills the bottom
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;      // |divisor|
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_result;
   logic             r_req_ready;
   logic             r_resp_valid;
   logic             r_busy;

   // Request decode: operand magnitudes and the two short-circuit cases
   logic             w_signed;
   logic             w_div_zero;
   logic             w_ovf;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_special;

   assign w_signed   = ~bus.op[0];
   assign w_div_zero = (bus.operand2 == '0);
   assign w_ovf      = w_signed && (bus.operand1 == C_MIN) && (bus.operand2 == '1);
   assign w_abs_a    = (w_signed && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
   assign w_abs_b    = (w_signed && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;
   assign w_special  = w_div_zero ? (bus.op[1] ? bus.operand1 : '1)
                                  : (bus.op[1] ? '0 : C_MIN);

   // One restoring step; the compare is done at WIDTH+1 bits so a partial
   // remainder with its top bit set still compares correctly.
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;
   logic [WIDTH-1:0] w_rem_nx;

   assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_div};
   assign w_qbit   = ~w_diff[WIDTH];
   assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

   // Sign fix-up applied when leaving CALC
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
   assign w_r_fix = r_neg_r ? -r_rem : r_rem;

   // Control FSM and datapath with registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_dvd        <= '0;
         r_rem        <= '0;
         r_div        <= '0;
         r_is_rem     <= 1'b0;
         r_neg_q      <= 1'b0;
         r_neg_r      <= 1'b0;
         r_result     <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (w_div_zero || w_ovf) begin
                     r_result     <= w_special;
                     r_resp_valid <= 1'b1;
                     r_state      <= S_DONE;
                  end else begin
                     r_dvd    <= w_abs_a;
                     r_div    <= w_abs_b;
                     r_rem    <= '0;
                     r_cnt    <= '0;
                     r_is_rem <= bus.op[1];
                     r_neg_q  <= w_signed && (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
                     r_neg_r  <= w_signed && bus.operand1[WIDTH-1];
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (r_cnt == C_LAST) begin
                  r_result     <= r_is_rem ? w_r_fix : w_q_fix;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_rem <= w_rem_nx;
                  r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.result     = r_result;
   assign bus.busy       = r_busy;

endmodule
`default_nettype wire
